// File: rtl/decode_64b67b_gearbox_pkg.sv
// -----------------------------------------------------------------------------
// decode_64b67b_gearbox_pkg
// Shared constants and types for the 64b/67b receive gearbox and its lock FSM.
// Block layout (LSB first on the wire): [63:0] payload, [65:64] sync header,
// [66] inversion flag.
// -----------------------------------------------------------------------------
package decode_64b67b_gearbox_pkg;

   localparam int BLOCK_W   = 67;
   localparam int PAYLOAD_W = 64;
   localparam int HDR_LO    = 64;
   localparam int HDR_HI    = 65;
   localparam int INV_BIT   = 66;

   // Two blocks' worth of storage. Fill is at most 66 before an append and a
   // word is at most 67 bits wide, so the buffer never holds more than 133.
   localparam int BUF_W     = 2 * BLOCK_W;
   localparam int FILL_W    = 8;

   typedef enum logic {
      ST_SYNCING = 1'b0,
      ST_LOCKED  = 1'b1
   } lockState_t;

   // A sync header is good only when its two bits differ.
   function automatic logic isGoodHeader(input logic [1:0] hdr);
      return hdr[1] ^ hdr[0];
   endfunction

endpackage

// File: rtl/decode_64b67b_gearbox_rx.sv
// -----------------------------------------------------------------------------
// gearbox_67b_rx
// Receive gearbox: packs DATA_W-bit words into a bit buffer, hands out one
// 67-bit block whenever enough bits are present, and performs one-bit slips
// for alignment search.
// Ports:
//   i_clk, i_rst   clock and asynchronous active-high reset
//   i_data         input word, bit 0 earliest on the wire
//   i_valid        i_data carries new bits this cycle
//   i_flush        empty the buffer and drop any pending slip
//   i_slipReq      request a one-bit slip (sampled on extraction cycles)
//   o_block        block at the head of the buffer (after this cycle's append)
//   o_blkValid     o_block is extracted this cycle
// -----------------------------------------------------------------------------
module gearbox_67b_rx
   import decode_64b67b_gearbox_pkg::*;
#(
   parameter int DATA_W = 64
)
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [DATA_W-1:0]  i_data,
   input  logic               i_valid,
   input  logic               i_flush,
   input  logic               i_slipReq,
   output logic [BLOCK_W-1:0] o_block,
   output logic               o_blkValid
);

   logic [BUF_W-1:0]  r_buf;
   logic [FILL_W-1:0] r_fill;
   logic              r_slipPending;

   logic [BUF_W-1:0]  w_bufA;
   logic [FILL_W-1:0] w_fillA;
   logic              w_extract;
   logic              w_slip;

   // Append the incoming word just above the current fill level, then decide
   // whether this cycle extracts a block or, failing that, executes a pending
   // slip. Slips only run in cycles with no extraction and at least one bit
   // in the buffer, so a slip never races a block out of the head.
   always_comb begin
      w_bufA  = r_buf;
      w_fillA = r_fill;
      if (i_valid) begin
         w_bufA  = r_buf | (BUF_W'(i_data) << r_fill);
         w_fillA = r_fill + FILL_W'(DATA_W);
      end
      w_extract = !i_flush && (w_fillA >= FILL_W'(BLOCK_W));
      w_slip    = !i_flush && !w_extract && r_slipPending && (w_fillA != '0);
   end

   assign o_block    = w_bufA[BLOCK_W-1:0];
   assign o_blkValid = w_extract;

   // Buffer state. Shifting right always brings zeros in from the top, which
   // keeps every bit above the fill level clear for the next OR-append. A new
   // slip request merges into the single pending flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_buf         <= '0;
         r_fill        <= '0;
         r_slipPending <= 1'b0;
      end else if (i_flush) begin
         r_buf         <= '0;
         r_fill        <= '0;
         r_slipPending <= 1'b0;
      end else if (w_extract) begin
         r_buf         <= w_bufA >> BLOCK_W;
         r_fill        <= w_fillA - FILL_W'(BLOCK_W);
         r_slipPending <= r_slipPending | i_slipReq;
      end else if (w_slip) begin
         r_buf         <= w_bufA >> 1;
         r_fill        <= w_fillA - FILL_W'(1);
         r_slipPending <= 1'b0;
      end else begin
         r_buf         <= w_bufA;
         r_fill        <= w_fillA;
      end
   end

endmodule

// File: rtl/decode_64b67b_gearbox.sv
// -----------------------------------------------------------------------------
// decode_64b67b_gearbox
// 64b/67b receive path: gearbox, sync-header lock FSM and registered outputs.
// Ports:
//   USER_CLK, SYSTEM_RESET  clock and asynchronous active-high reset
//   DATA_IN, DATA_IN_VALID  serial stream words, bit 0 earliest
//   PASSTHROUGH             bypass decoding, DATA_IN goes straight out
//   DATA_OUT, HEADER_OUT    decoded payload and sync header, registered
//   DATA_OUT_VALID          one pulse per block (or per passthrough word)
//   LOCKED                  FSM is in the LOCKED state
//   ERR_CNT                 saturating count of bad headers seen while locked
// -----------------------------------------------------------------------------
module decode_64b67b_gearbox
   import decode_64b67b_gearbox_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int LOCK_CNT  = 64,
   parameter int WIN_LEN   = 64,
   parameter int ERR_LIMIT = 16
)
(
   input  logic                 USER_CLK,
   input  logic                 SYSTEM_RESET,
   input  logic [DATA_W-1:0]    DATA_IN,
   input  logic                 DATA_IN_VALID,
   input  logic                 PASSTHROUGH,
   output logic [PAYLOAD_W-1:0] DATA_OUT,
   output logic [1:0]           HEADER_OUT,
   output logic                 DATA_OUT_VALID,
   output logic                 LOCKED,
   output logic [15:0]          ERR_CNT
);

   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W  = $clog2(WIN_LEN + 1);
   localparam int BAD_W  = $clog2(ERR_LIMIT + 1);
   localparam int PT_W   = (DATA_W > PAYLOAD_W) ? DATA_W : PAYLOAD_W;

   lockState_t          r_state;
   logic [GOOD_W-1:0]   r_goodCtr;
   logic [WIN_W-1:0]    r_winCtr;
   logic [BAD_W-1:0]    r_badCtr;
   logic [15:0]         r_errCnt;
   logic [PAYLOAD_W-1:0] r_dataOut;
   logic [1:0]          r_hdrOut;
   logic                r_validOut;

   logic [BLOCK_W-1:0]   w_block;
   logic                 w_blkValid;
   logic                 w_good;
   logic                 w_slipReq;
   logic [PAYLOAD_W-1:0] w_payload;
   logic [PT_W-1:0]      w_ptWide;

   gearbox_67b_rx #(.DATA_W(DATA_W)) u_gearbox (
      .i_clk      (USER_CLK),
      .i_rst      (SYSTEM_RESET),
      .i_data     (DATA_IN),
      .i_valid    (DATA_IN_VALID),
      .i_flush    (PASSTHROUGH),
      .i_slipReq  (w_slipReq),
      .o_block    (w_block),
      .o_blkValid (w_blkValid)
   );

   // Only a bad block seen while still searching for alignment asks the
   // gearbox to slip; errors while locked are counted instead.
   assign w_good    = isGoodHeader(w_block[HDR_HI:HDR_LO]);
   assign w_slipReq = w_blkValid && (r_state == ST_SYNCING) && !w_good;
   assign w_payload = w_block[INV_BIT] ? ~w_block[PAYLOAD_W-1:0]
                                       : w_block[PAYLOAD_W-1:0];
   assign w_ptWide  = PT_W'(DATA_IN);

   // Lock FSM. In SYNCING, LOCK_CNT consecutive good headers lock. In LOCKED,
   // blocks are grouped into windows of WIN_LEN; reaching ERR_LIMIT bad headers
   // inside a window unlocks, and that check is made before the end-of-window
   // clear so a limit hit on the last block still unlocks.
   always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
      if (SYSTEM_RESET) begin
         r_state   <= ST_SYNCING;
         r_goodCtr <= '0;
         r_winCtr  <= '0;
         r_badCtr  <= '0;
         r_errCnt  <= '0;
      end else if (PASSTHROUGH) begin
         r_state   <= ST_SYNCING;
         r_goodCtr <= '0;
         r_winCtr  <= '0;
         r_badCtr  <= '0;
      end else if (w_blkValid) begin
         case (r_state)
            ST_SYNCING: begin
               if (!w_good) begin
                  r_goodCtr <= '0;
               end else if (r_goodCtr == GOOD_W'(LOCK_CNT - 1)) begin
                  r_state   <= ST_LOCKED;
                  r_goodCtr <= '0;
                  r_winCtr  <= '0;
                  r_badCtr  <= '0;
               end else begin
                  r_goodCtr <= r_goodCtr + GOOD_W'(1);
               end
            end
            ST_LOCKED: begin
               if (!w_good && (r_errCnt != 16'hFFFF)) begin
                  r_errCnt <= r_errCnt + 16'd1;
               end
               if (!w_good && (r_badCtr == BAD_W'(ERR_LIMIT - 1))) begin
                  r_state   <= ST_SYNCING;
                  r_goodCtr <= '0;
                  r_winCtr  <= '0;
                  r_badCtr  <= '0;
               end else if (r_winCtr == WIN_W'(WIN_LEN - 1)) begin
                  r_winCtr  <= '0;
                  r_badCtr  <= '0;
               end else begin
                  r_winCtr  <= r_winCtr + WIN_W'(1);
                  if (!w_good) begin
                     r_badCtr <= r_badCtr + BAD_W'(1);
                  end
               end
            end
            default: r_state <= ST_SYNCING;
         endcase
      end
   end

   // Output registers. Passthrough mirrors the input word one cycle later;
   // otherwise each extracted block is presented once with its header, and
   // the data holds between blocks.
   always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
      if (SYSTEM_RESET) begin
         r_dataOut  <= '0;
         r_hdrOut   <= '0;
         r_validOut <= 1'b0;
      end else if (PASSTHROUGH) begin
         r_dataOut  <= w_ptWide[PAYLOAD_W-1:0];
         r_hdrOut   <= 2'b00;
         r_validOut <= DATA_IN_VALID;
      end else begin
         r_validOut <= w_blkValid;
         if (w_blkValid) begin
            r_dataOut <= w_payload;
            r_hdrOut  <= w_block[HDR_HI:HDR_LO];
         end
      end
   end

   assign DATA_OUT       = r_dataOut;
   assign HEADER_OUT     = r_hdrOut;
   assign DATA_OUT_VALID = r_validOut;
   assign LOCKED         = (r_state == ST_LOCKED);
   assign ERR_CNT        = r_errCnt;

endmodule

// File: tb/tb_decode_64b67b_gearbox.sv
// -----------------------------------------------------------------------------
// tb_decode_64b67b_gearbox
// Directed bench for the 64b/67b gearbox: a 64-bit and a 40-bit instance share
// one clock. Blocks are built as bit streams, fed word by word, and each
// output block is captured for comparison against hand-derived values.
// -----------------------------------------------------------------------------
module tb_decode_64b67b_gearbox;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;

   logic [63:0] dIn64;
   logic        vIn64;
   logic        pt64;
   logic [63:0] dOut64;
   logic [1:0]  hOut64;
   logic        vOut64;
   logic        lk64;
   logic [15:0] err64;

   logic [39:0] dIn40;
   logic        vIn40;
   logic        pt40;
   logic [63:0] dOut40;
   logic [1:0]  hOut40;
   logic        vOut40;
   logic        lk40;
   logic [15:0] err40;

   decode_64b67b_gearbox #(.DATA_W(64)) dut64 (
      .USER_CLK       (clock),
      .SYSTEM_RESET   (reset),
      .DATA_IN        (dIn64),
      .DATA_IN_VALID  (vIn64),
      .PASSTHROUGH    (pt64),
      .DATA_OUT       (dOut64),
      .HEADER_OUT     (hOut64),
      .DATA_OUT_VALID (vOut64),
      .LOCKED         (lk64),
      .ERR_CNT        (err64)
   );

   decode_64b67b_gearbox #(.DATA_W(40)) dut40 (
      .USER_CLK       (clock),
      .SYSTEM_RESET   (reset),
      .DATA_IN        (dIn40),
      .DATA_IN_VALID  (vIn40),
      .PASSTHROUGH    (pt40),
      .DATA_OUT       (dOut40),
      .HEADER_OUT     (hOut40),
      .DATA_OUT_VALID (vOut40),
      .LOCKED         (lk40),
      .ERR_CNT        (err40)
   );

   bit          bitQ[$];
   logic [63:0] obsData[$];
   logic [1:0]  obsHdr[$];
   logic        obsLk[$];
   logic [63:0] obs40Data[$];
   logic        obs40Lk[$];

   int checks = 0;
   int errors = 0;
   int wordsFed40 = 0;
   bit midChecked = 1'b0;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   // Payload whose top 23 bits are ones: any misaligned frame within 23 bits
   // of true alignment then sees two equal header bits and is rejected.
   function automatic logic [63:0] payloadOf(input int i);
      logic [31:0] idx;
      idx = i;
      return {23'h7F_FFFF, idx[8:0], idx ^ 32'h5A3C_96E1};
   endfunction

   task automatic pushBlock(input logic inv, input logic [1:0] hdr,
                            input logic [63:0] pl);
      for (int b = 0; b < 64; b++) bitQ.push_back(pl[b]);
      bitQ.push_back(hdr[0]);
      bitQ.push_back(hdr[1]);
      bitQ.push_back(inv);
   endtask

   // Advance one clock and capture any block presented by either instance.
   task automatic step();
      @(posedge clock);
      #1;
      if (vOut64 === 1'b1) begin
         obsData.push_back(dOut64);
         obsHdr.push_back(hOut64);
         obsLk.push_back(lk64);
      end
      if (vOut40 === 1'b1) begin
         obs40Data.push_back(dOut40);
         obs40Lk.push_back(lk40);
      end
   endtask

   task automatic clearObs();
      obsData.delete();
      obsHdr.delete();
      obsLk.delete();
      obs40Data.delete();
      obs40Lk.delete();
   endtask

   task automatic doReset();
      reset = 1'b1;
      vIn64 = 1'b0; vIn40 = 1'b0;
      pt64  = 1'b0; pt40  = 1'b0;
      dIn64 = '0;   dIn40 = '0;
      step();
      step();
      reset = 1'b0;
      bitQ.delete();
      clearObs();
   endtask

   // Feed the bit queue. The 64-bit instance gets continuous valid words,
   // zero-padding the final one; the 40-bit instance gets valid on every other
   // cycle and only full words, leaving any remainder queued.
   task automatic applyStimulus(input bit narrow, input int extra);
      bit toggle;
      toggle = 1'b0;
      if (!narrow) begin
         while (bitQ.size() > 0) begin
            for (int b = 0; b < 64; b++) begin
               if (bitQ.size() > 0) dIn64[b] = bitQ.pop_front();
               else                 dIn64[b] = 1'b0;
            end
            vIn64 = 1'b1;
            step();
         end
         vIn64 = 1'b0;
      end else begin
         while (bitQ.size() >= 40) begin
            toggle = ~toggle;
            if (toggle) begin
               for (int b = 0; b < 40; b++) dIn40[b] = bitQ.pop_front();
               vIn40 = 1'b1;
            end else begin
               vIn40 = 1'b0;
            end
            step();
            if (toggle) wordsFed40++;
            if (wordsFed40 == 67 && !midChecked) begin
               midChecked = 1'b1;
               checkOutput("t7_blocks_after_67_words", 64'(obs40Data.size()), 64'd40);
            end
         end
         vIn40 = 1'b0;
      end
      repeat (extra) step();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int budget;
      bit seen;
      bit toggle;
      logic [1:0] hdr;

      $display("[TB] start");
      doReset();
      checkOutput("rst_valid",  64'(vOut64), 64'd0);
      checkOutput("rst_locked", 64'(lk64),   64'd0);
      checkOutput("rst_errcnt", 64'(err64),  64'd0);
      checkOutput("rst_data",   dOut64,      64'd0);
      checkOutput("rst_hdr",    64'(hOut64), 64'd0);

      // Aligned stream: lock on the 64th block, payloads in order.
      for (int i = 0; i < 70; i++) pushBlock(1'b0, 2'b01, payloadOf(i));
      applyStimulus(1'b0, 3);
      checkOutput("t1_count",       64'(obsData.size()), 64'd70);
      checkOutput("t1_unlocked_63", 64'(obsLk[62]),      64'd0);
      checkOutput("t1_locked_64",   64'(obsLk[63]),      64'd1);
      checkOutput("t1_hdr",         64'(obsHdr[69]),     64'd1);
      for (int i = 0; i < 70; i++) checkOutput("t1_data", obsData[i], payloadOf(i));

      // 23-bit junk prefix: 21 bad blocks per slip period, 23 periods, then
      // 64 good blocks lock on block index 546, which is stream block 546.
      doReset();
      for (int j = 0; j < 23; j++) bitQ.push_back(j[0]);
      for (int i = 0; i < 600; i++) pushBlock(1'b0, 2'b01, payloadOf(i));
      applyStimulus(1'b0, 3);
      checkOutput("t2_first_aligned", obsData[483], payloadOf(483));
      checkOutput("t2_unlocked_546",  64'(obsLk[545]), 64'd0);
      checkOutput("t2_locked_547",    64'(obsLk[546]), 64'd1);
      for (int i = 546; i < 560; i++) checkOutput("t2_data", obsData[i], payloadOf(i));
      checkOutput("t2_errcnt", 64'(err64), 64'd0);

      // 16 bad headers in one window: unlock on the 16th (block 94).
      doReset();
      for (int i = 0; i < 100; i++) begin
         hdr = (i >= 64 && i <= 94 && ((i - 64) % 2) == 0) ? 2'b11 : 2'b01;
         pushBlock(1'b0, hdr, payloadOf(i));
      end
      applyStimulus(1'b0, 3);
      checkOutput("t3_locked_93",   64'(obsLk[93]),  64'd1);
      checkOutput("t3_unlocked_94", 64'(obsLk[94]),  64'd0);
      checkOutput("t3_bad_hdr",     64'(obsHdr[94]), 64'd3);
      checkOutput("t3_errcnt",      64'(err64),      64'd16);
      checkOutput("t3_locked_end",  64'(lk64),       64'd0);

      // 16th bad header on the last block of the window still unlocks.
      doReset();
      for (int i = 0; i < 135; i++) begin
         hdr = (i >= 112 && i <= 127) ? 2'b11 : 2'b01;
         pushBlock(1'b0, hdr, payloadOf(i));
      end
      applyStimulus(1'b0, 3);
      checkOutput("t5_locked_127",   64'(obsLk[126]), 64'd1);
      checkOutput("t5_unlocked_128", 64'(obsLk[127]), 64'd0);
      checkOutput("t5_errcnt",       64'(err64),      64'd16);

      // 15 bad headers per window for 10 windows: stays locked, 150 errors.
      doReset();
      for (int i = 0; i < 710; i++) begin
         hdr = (i >= 64 && i < 704 && (((i - 64) % 64) % 4) == 3 &&
                ((i - 64) % 64) >= 7) ? 2'b11 : 2'b01;
         pushBlock(1'b0, hdr, payloadOf(i));
      end
      applyStimulus(1'b0, 3);
      checkOutput("t4_locked_704", 64'(obsLk[703]), 64'd1);
      checkOutput("t4_locked_end", 64'(lk64),       64'd1);
      checkOutput("t4_errcnt",     64'(err64),      64'd150);
      checkOutput("t4_data",       obsData[700],    payloadOf(700));

      // Passthrough: input mirrored, FSM forced out of lock, ERR_CNT held.
      pt64  = 1'b1;
      dIn64 = 64'hDEAD_BEEF_0123_4567;
      vIn64 = 1'b1;
      step();
      checkOutput("pt_data",   dOut64,       64'hDEAD_BEEF_0123_4567);
      checkOutput("pt_hdr",    64'(hOut64),  64'd0);
      checkOutput("pt_valid",  64'(vOut64),  64'd1);
      checkOutput("pt_locked", 64'(lk64),    64'd0);
      checkOutput("pt_errcnt", 64'(err64),   64'd150);
      vIn64 = 1'b0;
      step();
      checkOutput("pt_valid_low", 64'(vOut64), 64'd0);
      pt64 = 1'b0;
      clearObs();
      bitQ.delete();
      for (int i = 0; i < 70; i++) pushBlock(1'b0, 2'b01, payloadOf(i));
      applyStimulus(1'b0, 3);
      checkOutput("pt_resync_first",  obsData[0],      payloadOf(0));
      checkOutput("pt_resync_63",     64'(obsLk[62]),  64'd0);
      checkOutput("pt_resync_64",     64'(obsLk[63]),  64'd1);
      checkOutput("pt_resync_errcnt", 64'(err64),      64'd150);

      // Inversion flag set: payload is complemented on output.
      doReset();
      pushBlock(1'b1, 2'b01, 64'h0123_4567_89AB_CDEF);
      applyStimulus(1'b0, 3);
      checkOutput("t6_count", 64'(obsData.size()), 64'd1);
      checkOutput("t6_data",  obsData[0],          64'hFEDC_BA98_7654_3210);
      checkOutput("t6_hdr",   64'(obsHdr[0]),      64'd1);

      // 40-bit words with valid toggling; block 66 carries a bad header.
      doReset();
      wordsFed40 = 0;
      midChecked = 1'b0;
      for (int i = 0; i < 70; i++) begin
         hdr = (i == 66) ? 2'b11 : 2'b01;
         pushBlock(1'b0, hdr, payloadOf(i));
      end
      applyStimulus(1'b1, 2);
      checkOutput("t7_mid_reached", 64'(midChecked),        64'd1);
      checkOutput("t7_count",       64'(obs40Data.size()),  64'd69);
      checkOutput("t7_unlocked_63", 64'(obs40Lk[62]),       64'd0);
      checkOutput("t7_locked_64",   64'(obs40Lk[63]),       64'd1);
      checkOutput("t7_data_10",     obs40Data[10],          payloadOf(10));
      checkOutput("t7_data_68",     obs40Data[68],          payloadOf(68));
      checkOutput("t7_errcnt",      64'(err40),             64'd1);

      // Keep streaming until a block pulse, then reset in the middle of it.
      for (int i = 70; i < 75; i++) pushBlock(1'b0, 2'b01, payloadOf(i));
      budget = 0;
      seen   = 1'b0;
      toggle = 1'b0;
      while (!seen && budget < 200) begin
         toggle = ~toggle;
         if (toggle && bitQ.size() >= 40) begin
            for (int b = 0; b < 40; b++) dIn40[b] = bitQ.pop_front();
            vIn40 = 1'b1;
         end else begin
            vIn40 = 1'b0;
         end
         step();
         if (vOut40 === 1'b1) seen = 1'b1;
         budget++;
      end
      checkOutput("t7_pulse_seen",     64'(seen),   64'd1);
      checkOutput("t7_pre_rst_locked", 64'(lk40),   64'd1);
      checkOutput("t7_pre_rst_errcnt", 64'(err40),  64'd1);
      checkOutput("t7_data_69",        dOut40,      payloadOf(69));
      reset = 1'b1;
      vIn40 = 1'b0;
      #1;
      checkOutput("t7_rst_locked", 64'(lk40),   64'd0);
      checkOutput("t7_rst_valid",  64'(vOut40), 64'd0);
      checkOutput("t7_rst_errcnt", 64'(err40),  64'd0);
      checkOutput("t7_rst_data",   dOut40,      64'd0);
      step();
      reset = 1'b0;
      clearObs();
      repeat (5) step();
      checkOutput("t7_no_stale_pulse", 64'(obs40Data.size()), 64'd0);

      // Passthrough on the narrow instance zero-extends the word.
      pt40  = 1'b1;
      dIn40 = 40'hAB_CDEF_0123;
      vIn40 = 1'b1;
      step();
      checkOutput("t7_pt_data",  dOut40,      64'h0000_00AB_CDEF_0123);
      checkOutput("t7_pt_valid", 64'(vOut40), 64'd1);
      checkOutput("t7_pt_hdr",   64'(hOut40), 64'd0);
      pt40  = 1'b0;
      vIn40 = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
